// File: rtl/conv_pkg.sv
// Shared parameters, FSM encoding and window tap helpers for the 3x3 window builder.
package conv_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_IMG_W  = 640;
    localparam int unsigned DEF_COL_W  = 10;
    localparam int unsigned DEF_ROW_W  = 15;

    localparam int unsigned WIN_DIM       = 3;
    localparam int unsigned WIN_TAPS      = WIN_DIM * WIN_DIM;
    localparam int unsigned ROWS_LOADED_W = 2;

    // Window row (r) and column (k) indices; tap (r,k) sits at flat slot 3*r+k.
    localparam int unsigned WIN_TOP   = 0;
    localparam int unsigned WIN_MID   = 1;
    localparam int unsigned WIN_BOT   = 2;
    localparam int unsigned WIN_LEFT  = 0;
    localparam int unsigned WIN_CTR   = 1;
    localparam int unsigned WIN_RIGHT = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROW   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/line_buffer_2row.sv
// Two cascaded row buffers, IMG_W deep: one read and one write per cycle at the same
// column, read-before-write. Contents are not reset; the caller gates their use.
module line_buffer_2row
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned COL_W  = DEF_COL_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [COL_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_lb0_c,
    output logic [DATA_W-1:0] o_lb1_c
);

    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];

    assign o_lb0_c = r_lb0[i_addr];
    assign o_lb1_c = r_lb1[i_addr];

    // The newest row moves into lb0 while lb0's old pixel ages into lb1.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_lb1[i_addr] <= r_lb0[i_addr];
            r_lb0[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/conv_window_3x3.sv
// Builds zero-padded 3x3 windows from a raster pixel stream, one row per row_go,
// and reports row completion back to the row sequencer.
module conv_window_3x3
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned COL_W  = DEF_COL_W,
    parameter int unsigned ROW_W  = DEF_ROW_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       row_go,
    input  logic [ROW_W-1:0]           row_idx,
    input  logic                       zero_row,
    input  logic                       final_row,
    input  logic                       frame_finish,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_pixel,
    output logic                       win_valid,
    output logic [WIN_TAPS*DATA_W-1:0] win_out,
    output logic [COL_W-1:0]           win_col,
    output logic                       row_done
);

    localparam logic [COL_W-1:0]         LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0]         FIRST_EMIT = COL_W'(1);
    localparam logic [ROWS_LOADED_W-1:0] ROWS_FULL = ROWS_LOADED_W'(2);

    typedef logic [WIN_DIM-1:0][WIN_DIM-1:0][DATA_W-1:0] win_t;
    typedef logic [WIN_DIM-1:0][DATA_W-1:0]              col_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [COL_W-1:0]           r_col;
    logic [COL_W-1:0]           w_col_next;
    logic [ROWS_LOADED_W-1:0]   r_rows_loaded;
    logic [ROWS_LOADED_W-1:0]   w_rows_next;
    logic                       r_pad;
    logic                       w_pad_next;
    logic                       r_emit;
    logic                       w_emit_next;
    logic [ROW_W-1:0]           r_row_idx;
    logic [ROW_W-1:0]           w_row_idx_next;

    logic                       r_in_ready;
    logic                       w_in_ready_next;
    logic                       r_win_valid;
    logic                       w_win_valid_next;
    logic [COL_W-1:0]           r_win_col;
    logic [COL_W-1:0]           w_win_col_next;
    logic                       r_row_done;
    logic                       w_row_done_next;

    logic                       w_take;
    logic                       w_shift_out;
    logic                       w_flush_out;
    logic                       w_first_col;
    logic [DATA_W-1:0]          w_px;
    logic [DATA_W-1:0]          w_lb0;
    logic [DATA_W-1:0]          w_lb1;
    col_t                       w_col_vec;
    win_t                       r_win;
    win_t                       w_win_shift;
    win_t                       w_win_emit;
    win_t                       r_win_out;
    logic                       w_unused_diag;

    assign in_ready  = r_in_ready;
    assign win_valid = r_win_valid;
    assign win_col   = r_win_col;
    assign row_done  = r_row_done;
    assign win_out   = r_win_out;

    // The latched row index is kept for debug visibility only.
    assign w_unused_diag = ^r_row_idx;

    assign w_px   = r_pad ? '0 : in_pixel;
    assign w_take = (r_state == S_ROW) && (r_pad || (in_valid && r_in_ready));

    line_buffer_2row #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .COL_W  (COL_W)
    ) u_lb (
        .clk     (clk),
        .i_we    (w_take),
        .i_addr  (r_col),
        .i_wdata (w_px),
        .o_lb0_c (w_lb0),
        .o_lb1_c (w_lb1)
    );

    // Next-state and registered-output decode.
    always_comb begin
        w_state_next     = r_state;
        w_col_next       = r_col;
        w_rows_next      = r_rows_loaded;
        w_pad_next       = r_pad;
        w_emit_next      = r_emit;
        w_row_idx_next   = r_row_idx;
        w_in_ready_next  = 1'b0;
        w_win_valid_next = 1'b0;
        w_win_col_next   = r_win_col;
        w_row_done_next  = 1'b0;
        w_shift_out      = 1'b0;
        w_flush_out      = 1'b0;

        if (frame_finish) begin
            w_rows_next = '0;
        end

        unique case (r_state)
            S_IDLE: begin
                if (row_go) begin
                    w_state_next    = S_ROW;
                    w_pad_next      = zero_row | final_row;
                    w_col_next      = '0;
                    w_emit_next     = (w_rows_next == ROWS_FULL);
                    w_row_idx_next  = row_idx;
                    w_in_ready_next = !(zero_row | final_row);
                end
            end
            S_ROW: begin
                w_in_ready_next = !r_pad;
                if (w_take) begin
                    w_shift_out = r_emit && (r_col != '0);
                    w_col_next  = r_col + COL_W'(1);
                    if (r_col == LAST_COL) begin
                        w_state_next    = S_FLUSH;
                        w_col_next      = '0;
                        w_in_ready_next = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                w_state_next    = S_DONE;
                w_flush_out     = r_emit;
                w_row_done_next = 1'b1;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                if (!frame_finish) begin
                    w_rows_next = (r_rows_loaded == ROWS_FULL) ? ROWS_FULL
                                                               : r_rows_loaded + ROWS_LOADED_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_shift_out) begin
            w_win_valid_next = 1'b1;
            w_win_col_next   = r_col - COL_W'(1);
        end
        if (w_flush_out) begin
            w_win_valid_next = 1'b1;
            w_win_col_next   = LAST_COL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_col         <= '0;
            r_rows_loaded <= '0;
            r_pad         <= 1'b0;
            r_emit        <= 1'b0;
            r_row_idx     <= '0;
            r_in_ready    <= 1'b0;
            r_win_valid   <= 1'b0;
            r_win_col     <= '0;
            r_row_done    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_col         <= w_col_next;
            r_rows_loaded <= w_rows_next;
            r_pad         <= w_pad_next;
            r_emit        <= w_emit_next;
            r_row_idx     <= w_row_idx_next;
            r_in_ready    <= w_in_ready_next;
            r_win_valid   <= w_win_valid_next;
            r_win_col     <= w_win_col_next;
            r_row_done    <= w_row_done_next;
        end
    end

    // Flush shifts in an all-zero column, which supplies the right-border padding.
    assign w_col_vec   = w_flush_out ? '0 : {w_px, w_lb0, w_lb1};
    assign w_first_col = (r_state == S_ROW) && (r_col == FIRST_EMIT);

    always_comb begin
        w_win_shift          = r_win;
        w_win_shift[WIN_TOP] = {w_col_vec[WIN_TOP], r_win[WIN_TOP][WIN_RIGHT], r_win[WIN_TOP][WIN_CTR]};
        w_win_shift[WIN_MID] = {w_col_vec[WIN_MID], r_win[WIN_MID][WIN_RIGHT], r_win[WIN_MID][WIN_CTR]};
        w_win_shift[WIN_BOT] = {w_col_vec[WIN_BOT], r_win[WIN_BOT][WIN_RIGHT], r_win[WIN_BOT][WIN_CTR]};

        w_win_emit = w_win_shift;
        if (w_first_col) begin
            w_win_emit[WIN_TOP][WIN_LEFT] = '0;
            w_win_emit[WIN_MID][WIN_LEFT] = '0;
            w_win_emit[WIN_BOT][WIN_LEFT] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win     <= '0;
            r_win_out <= '0;
        end else begin
            if (w_take) begin
                r_win <= w_win_shift;
            end
            if (w_win_valid_next) begin
                r_win_out <= w_win_emit;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_3x3.sv
// Scoreboard bench for conv_window_3x3 on a 4-wide, 3-row image with padding rows.
module tb_conv_window_3x3;

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned RW = 15;
    localparam int unsigned H  = 3;
    localparam int unsigned WW = 9 * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          row_go;
    logic [RW-1:0] row_idx;
    logic          zero_row;
    logic          final_row;
    logic          frame_finish;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pixel;
    logic          win_valid;
    logic [WW-1:0] win_out;
    logic [CW-1:0] win_col;
    logic          row_done;

    typedef struct packed {
        logic [CW-1:0] col;
        logic [WW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_win    = 0;

    always #5 clk = ~clk;

    conv_window_3x3 #(
        .DATA_W (DW),
        .IMG_W  (IW),
        .COL_W  (CW),
        .ROW_W  (RW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .row_go       (row_go),
        .row_idx      (row_idx),
        .zero_row     (zero_row),
        .final_row    (final_row),
        .frame_finish (frame_finish),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pixel     (in_pixel),
        .win_valid    (win_valid),
        .win_out      (win_out),
        .win_col      (win_col),
        .row_done     (row_done)
    );

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Taps listed top row first, left column first.
    function automatic logic [WW-1:0] pack9(input logic [7:0] t0, t1, t2, t3, t4, t5, t6, t7, t8);
        return {t8, t7, t6, t5, t4, t3, t2, t1, t0};
    endfunction

    // Reference window centred on image pixel (y,x) with zero padding outside the image.
    function automatic logic [WW-1:0] exp_window(input logic [7:0] base, input int y, input int x);
        logic [WW-1:0] w;
        int rr;
        int cc;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                rr = y - 1 + r;
                cc = x - 1 + k;
                if (rr >= 0 && rr < int'(H) && cc >= 0 && cc < int'(IW))
                    w[8*(3*r+k) +: 8] = base + 8'(16*rr + cc + 1);
            end
        end
        return w;
    endfunction

    // Monitor: every presented window must match the head of the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && win_valid === 1'b1) begin
                n_win++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_window actual_col=%0d win=%h required=none", win_col, win_out);
                end else begin
                    e = exp_q.pop_front();
                    check("win_col", WW'(win_col), WW'(e.col));
                    check("win_out", win_out, e.data);
                end
            end
        end
    end

    // Drives one sequencer row; entered and left just after a clock edge with the DUT idle.
    task automatic do_row(input int s, input logic [7:0] base, input bit gaps, input bit ff,
                          input bit chk, input int abort_col, output bit aborted);
        bit   pad;
        bit   bad;
        bit   rdy;
        bit   taken;
        int   n;
        exp_t e;
        pad     = (s == 0) || (s == int'(H) + 1);
        aborted = 1'b0;
        if (s >= 2) begin
            for (int x = 0; x < int'(IW); x++) begin
                e.col  = CW'(x);
                e.data = exp_window(base, s - 2, x);
                exp_q.push_back(e);
            end
        end
        row_go       = 1'b1;
        row_idx      = RW'(s);
        zero_row     = (s == 0);
        final_row    = (s == int'(H) + 1);
        frame_finish = ff;
        @(posedge clk); #1;
        row_go       = 1'b0;
        zero_row     = 1'b0;
        final_row    = 1'b0;
        frame_finish = 1'b0;
        if (pad) begin
            in_valid = 1'b1;
            in_pixel = 8'hFF;
            bad      = 1'b0;
            n        = 1;
            forever begin
                @(negedge clk);
                if (row_done === 1'b1) break;
                if (in_ready !== 1'b0) bad = 1'b1;
                if (n >= 40) break;
                @(posedge clk); #1;
                n++;
            end
            in_valid = 1'b0;
            check("pad_in_ready_low", WW'(bad), WW'(0));
            check("pad_row_done_latency", WW'(n), WW'(IW + 2));
        end else begin
            for (int c = 0; c < int'(IW); c++) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) begin
                        in_valid = 1'b0;
                        in_pixel = 8'($urandom);
                        @(posedge clk); #1;
                    end
                end
                in_valid = 1'b1;
                in_pixel = base + 8'(16*(s-1) + c + 1);
                taken    = 1'b0;
                for (int t = 0; t < 20 && !taken; t++) begin
                    rdy = in_ready;
                    @(posedge clk); #1;
                    taken = rdy;
                end
                if (!taken) begin
                    check("pixel_accept_timeout", WW'(0), WW'(1));
                    in_valid = 1'b0;
                    return;
                end
                if (chk && c == 1) begin
                    @(negedge clk);
                    check("first_win_valid", WW'(win_valid), WW'(1));
                    check("first_win_col", WW'(win_col), WW'(0));
                    check("first_win_out", win_out, pack9(0, 0, 0, 0, 1, 2, 0, 17, 18));
                end
                if (c == abort_col) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    check("pre_reset_win_valid", WW'(win_valid), WW'(1));
                    #2 reset = 1'b1;
                    #1;
                    check("async_reset_in_ready", WW'(in_ready), WW'(0));
                    check("async_reset_win_valid", WW'(win_valid), WW'(0));
                    check("async_reset_row_done", WW'(row_done), WW'(0));
                    check("async_reset_win_out", win_out, WW'(0));
                    exp_q.delete();
                    @(posedge clk); #1;
                    reset   = 1'b0;
                    aborted = 1'b1;
                    return;
                end
            end
            in_valid = 1'b0;
            n = 0;
            forever begin
                @(negedge clk);
                if (row_done === 1'b1) break;
                if (n >= 40) begin
                    check("row_done_timeout", WW'(0), WW'(1));
                    break;
                end
                @(posedge clk); #1;
                n++;
            end
            if (chk) begin
                check("flush_win_valid", WW'(win_valid), WW'(1));
                check("flush_win_col", WW'(win_col), WW'(3));
                check("flush_win_out", win_out, pack9(0, 0, 0, 3, 4, 0, 19, 20, 0));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input logic [7:0] base, input int gap_s, input bit ff_first,
                             input bit chk, input int abort_s, input int abort_c);
        int start;
        bit ab;
        start = n_win;
        for (int s = 0; s <= int'(H) + 1; s++) begin
            do_row(s, base, s == gap_s, ff_first && s == 0, chk && s == 2,
                   (s == abort_s) ? abort_c : -1, ab);
            if (ab) return;
        end
        check("frame_window_count", WW'(n_win - start), WW'(H * IW));
        check("frame_queue_empty", WW'(exp_q.size()), WW'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        row_go       = 1'b0;
        row_idx      = '0;
        zero_row     = 1'b0;
        final_row    = 1'b0;
        frame_finish = 1'b0;
        in_valid     = 1'b0;
        in_pixel     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", WW'(in_ready), WW'(0));
        check("reset_win_valid", WW'(win_valid), WW'(0));
        check("reset_row_done", WW'(row_done), WW'(0));
        check("reset_win_out", win_out, WW'(0));
        check("reset_win_col", WW'(win_col), WW'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Gap-free frame with hand-checked first and right-border windows.
        run_frame(8'h00, -1, 1'b0, 1'b1, -1, -1);

        // Standalone end-of-frame, then the same image with bubbles on r1.
        frame_finish = 1'b1;
        @(posedge clk); #1;
        frame_finish = 1'b0;
        run_frame(8'h00, 2, 1'b0, 1'b1, -1, -1);

        // End-of-frame coinciding with the first row_go of the next frame.
        run_frame(8'h40, -1, 1'b1, 1'b0, -1, -1);

        // Reset in the middle of r1 while windows are streaming, then a fresh frame.
        run_frame(8'h20, -1, 1'b1, 1'b0, 2, 1);
        run_frame(8'h10, 3, 1'b0, 1'b0, -1, -1);

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", WW'(exp_q.size()), WW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_3x3.md
Name: conv_window_3x3

Overview:
- Downstream consumer of the 640-row padded row sequencer. It takes that sequencer's row descriptor (row index, zero_row, final_row, finish) and a raster pixel stream.
- Builds 3x3 convolution windows with zero padding on all four borders, using two internal line buffers.
- Feeds the first 3x3 conv/MAC stage.
- Emits row_done once per row so the sequencer advances exactly one row per completed row.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 640, pixels per row
- COL_W, 10, column counter width, equal to clog2(IMG_W)
- ROW_W, 15, width of the incoming row index, matching the sequencer count

Ports:
- clk  input  1  single clock for the whole block
- reset  input  1  asynchronous, active-high reset
- row_go  input  1  one-cycle pulse: start a row; descriptor inputs sampled this cycle
- row_idx  input  ROW_W  row index from the sequencer; latched, diagnostic only
- zero_row  input  1  top padding row; the row is all zeros
- final_row  input  1  bottom padding row; the row is all zeros
- frame_finish  input  1  end-of-frame pulse from the sequencer
- in_valid  input  1  pixel valid
- in_ready  output  1  block accepts a pixel this cycle
- in_pixel  input  DATA_W  pixel, raster order
- win_valid  output  1  window valid, one-cycle pulse per window
- win_out  output  9*DATA_W  window, slice [DATA_W*(3*r+k) +: DATA_W]; r=0 is the oldest (top) row, k=0 is the left column
- win_col  output  COL_W  center column of win_out
- row_done  output  1  one-cycle pulse when a row completes

Behaviour:
- Reset (async): state=S_IDLE, col=0, rows_loaded=0, pad=0, in_ready=0, win_valid=0, win_out=0, win_col=0, row_done=0. Line-buffer RAM is not reset; rows_loaded gates all output.
- States:
  - S_IDLE: in_ready=0. On row_go: latch pad=zero_row|final_row, clear col, go to S_ROW.
  - S_ROW:
    - pad=0: in_ready=1; col advances on each in_valid&in_ready.
    - pad=1: in_ready=0; one zero column is injected per cycle, no stalls.
    - Leave after column IMG_W-1 is taken; go to S_FLUSH.
  - S_FLUSH: one cycle, then go to S_DONE.
  - S_DONE: row_done=1 for one cycle, rows_loaded=min(rows_loaded+1,2), go to S_IDLE.
- Column shift, per taken column c:
  - New column vector {lb1[c], lb0[c], px}, where px=0 on pad rows, shifts into the 3x3 window register.
  - lb1[c]<=lb0[c] and lb0[c]<=px.
- Emission:
  - Active only when rows_loaded==2 at row start.
  - For c>=1: win_valid is asserted the cycle after column c is taken, with win_col=c-1.
  - win_col=0: left column forced to 0.
  - S_FLUSH emits win_col=IMG_W-1 with the right column forced to 0.
  - Result: exactly IMG_W windows per emitting row.
- Frame: the sequence is pad, r0..r(H-1), pad, so the first emitting row centres r0 and the last centres r(H-1). That gives H*IMG_W windows per frame.
- frame_finish clears rows_loaded to 0.
  - If it coincides with row_go: clear first, then start the row.
  - Ignored outside S_IDLE except for the clear.
- in_valid bubbles stall col. No window is emitted without a newly taken column.
- No output backpressure: the consumer must accept every win_valid.
- row_go outside S_IDLE is ignored.
- Reset mid-row: everything above returns to reset values; the first subsequent frame needs two rows loaded before emitting.

Decomposition:
- Shared package conv_pkg holds:
  - DATA_W, IMG_W, COL_W, ROW_W defaults
  - state encoding S_IDLE/S_ROW/S_FLUSH/S_DONE
  - window index helper constants
- One sub-module, line_buffer_2row: dual row RAM, IMG_W deep, one read/one write per cycle at the same address, read-before-write.

Test Plan:
- Reset: assert reset mid-stream -> in_ready=0, win_valid=0, row_done=0, win_out=0 immediately, without waiting for a clock edge.
- Small frame, IMG_W=4, rows pad,r0,r1,r2,pad, pixel=16*row+col+1:
  - No win_valid during pad or r0.
  - First window appears the cycle after r1 col1 is taken: win_col=0, win_out={0,0,0, 0,1,2, 0,17,18}.
  - Total 12 windows for the frame.
- Right border: S_FLUSH on row r1 -> win_col=3, win_out={0,0,0, 3,4,0, 19,20,0}.
- Pad rows: zero_row row_go -> in_ready=0 for the whole row, row_done exactly IMG_W+2 cycles after row_go, in_pixel ignored.
- Bubbles: random in_valid gaps on r1 -> same window values and order as the gap-free run, one win_valid per taken column.
- frame_finish followed by a new frame -> no win_valid until the new frame's r1 row, first window centred at (0,0).
